apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Single-outstanding APB master placed directly upstream of the APB slave module (`APB_module`). It accepts read/write commands on a valid/ready interface and sequences each one through the APB SETUP and ACCESS phases. It then returns read data or a timeout error on a one-cycle response strobe. The bridge lets testbenches and on-chip logic drive the slave without hand-coding `PSEL`/`PENABLE` timing.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, width of `PADDR` and `cmd_addr`.
- `DATA_WIDTH`, 32, width of `PWDATA`, `PRDATA`, `cmd_wdata` and `rsp_rdata`.
- `TIMEOUT_CYCLES`, 16, number of ACCESS cycles with `PREADY`=0 that abort a transfer; legal range 1..255.

Ports:
- `PCLK`  in  1  sole clock; all logic is on the rising edge.
- `PRESET`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  bridge can accept a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  transfer address.
- `cmd_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_write`  out  1  direction of the completed transfer.
- `rsp_err`  out  1  1 = transfer aborted by timeout.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `PSEL`, `PENABLE`, `PWRITE`  out  1  APB control.
- `PADDR`  out  ADDR_WIDTH  APB address.
- `PWDATA`  out  DATA_WIDTH  APB write data.
- `PRDATA`  in  DATA_WIDTH  APB read data.
- `PREADY`  in  1  APB slave ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- `cmd_ready` = 1 only in IDLE. It is a registered state decode, with no combinational path from `cmd_valid`.
- **IDLE**
  - `PSEL`=0, `PENABLE`=0.
  - On `cmd_valid & cmd_ready`:
    - Latch `cmd_write`/`cmd_addr`/`cmd_wdata` into `PWRITE`/`PADDR`/`PWDATA`.
    - Clear the wait counter.
    - Go to SETUP.
- **SETUP**
  - `PSEL`=1, `PENABLE`=0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - `PSEL`=1, `PENABLE`=1.
  - If `PREADY`=1: complete the transfer.
    - Register `rsp_rdata` = (`PWRITE` ? 0 : `PRDATA`), `rsp_err`=0, `rsp_write`=`PWRITE`.
    - Pulse `rsp_valid`.
    - Go to IDLE.
  - Else if wait count = `TIMEOUT_CYCLES`-1: abort the transfer.
    - `rsp_err`=1, `rsp_rdata`=0.
    - Pulse `rsp_valid`.
    - Go to IDLE.
  - Else: increment the 8-bit wait counter and stay in ACCESS.
- `PADDR`, `PWDATA`, `PWRITE` hold stable from SETUP through the last ACCESS cycle. They retain their last values in IDLE.
- `rsp_*` fields hold until the next completion. Only `rsp_valid` is a pulse.
- No response backpressure: the consumer must take the response in the `rsp_valid` cycle.
- A `cmd_valid` asserted while not in IDLE is ignored and not queued. The requester must hold it until it sees `cmd_ready`.

## Timing
- Reset values, applied on the first edge where `PRESET`=1:
  - State = IDLE, `cmd_ready`=1.
  - `PSEL`=`PENABLE`=`PWRITE`=0, `PADDR`=0, `PWDATA`=0.
  - `rsp_valid`=`rsp_err`=`rsp_write`=0, `rsp_rdata`=0, wait counter = 0.
- Zero-wait transfer:
  - Accept at edge E0; SETUP during cycle E0..E1; ACCESS during E1..E2.
  - `PREADY` is sampled at E2.
  - `rsp_valid` is high during E2..E3.
  - Back in IDLE after E2, so the next command can be accepted at E3.
  - Total: 3 cycles from accept to response; 3-cycle issue interval.
- N wait states (`PREADY`=0 for N sampled ACCESS edges, N < `TIMEOUT_CYCLES`): `rsp_valid` arrives N cycles later than in the zero-wait case.
- Timeout: with `PREADY` held 0, `rsp_valid`/`rsp_err` assert in the cycle after the `TIMEOUT_CYCLES`-th ACCESS edge.
- If `PREADY`=1 on the same edge that would time out, completion wins and `rsp_err`=0.
- Reset mid-transfer (any state): next state is IDLE and all outputs take their reset values. No `rsp_valid` is emitted for the lost transfer.
- `PREADY` and `PRDATA` are ignored outside ACCESS.

## Test plan
- **Write, zero wait:** reset, then `cmd` write addr 0x10 data 0xDEADBEEF with `PREADY`=1.
  - `PSEL` rises 1 cycle after accept, `PENABLE` the cycle after that.
  - `PADDR`=0x10, `PWDATA`=0xDEADBEEF, `PWRITE`=1 held across both cycles.
  - `rsp_valid` 3 cycles after accept, `rsp_err`=0.
- **Readback:** read addr 0x10 from the slave model.
  - `rsp_rdata`=0xDEADBEEF, `rsp_write`=0, `PWRITE`=0 throughout.
- **Wait states:** read with `PREADY`=0 for the first 3 ACCESS edges.
  - `PENABLE` high for 4 cycles with address stable.
  - `rsp_valid` 6 cycles after accept.
  - `cmd_ready`=0 for the whole transfer.
- **Timeout:** `TIMEOUT_CYCLES`=4, `PREADY` held 0.
  - `rsp_err`=1 and `rsp_rdata`=0 in the cycle after the 4th ACCESS edge.
  - `PSEL`/`PENABLE` drop to 0 in that same cycle.
  - The next command is accepted normally.
- **Reset mid-ACCESS:** assert `PRESET` for 1 cycle during a wait state.
  - All outputs return to reset values at that edge.
  - No `rsp_valid` is emitted; `cmd_ready`=1 after the edge.
- **Back-to-back:** `cmd_valid` held high across 8 alternating write/read commands, `PREADY`=1.
  - One accept every 3 cycles, 8 responses in order.
  - Each read returns the preceding write's data.

Source files
------------

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Single-outstanding APB master. It accepts commands on a
//               valid/ready port, runs each one through the APB SETUP and
//               ACCESS phases, and returns read data or a timeout error on a
//               one-cycle response strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response port
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  // APB master port
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Wait count at which an ACCESS edge without PREADY aborts the transfer.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       complete;
  logic       abort;

  // State register; reset forces IDLE from any state, dropping a live transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and transfer-event decode.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        // A ready slave wins over a timeout that falls on the same edge.
        if (PREADY) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LIMIT) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control outputs are pure decodes of the state register, so cmd_ready
  // has no combinational path from cmd_valid.
  assign cmd_ready = (state == IDLE);
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);

  // Address/data capture and wait-state counting; values persist through IDLE.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      wait_cnt <= 8'd0;
    end else if (accept) begin
      PWRITE   <= cmd_write;
      PADDR    <= cmd_addr;
      PWDATA   <= cmd_wdata;
      wait_cnt <= 8'd0;
    end else if ((state == ACCESS) && !PREADY && !abort) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Response register: fields hold until the next completion, strobe is one cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= complete || abort;
      if (complete) begin
        rsp_write <= PWRITE;
        rsp_err   <= 1'b0;
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end else if (abort) begin
        rsp_write <= PWRITE;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Self-checking bench for apb_master_bridge. A memory-backed APB
//               slave with programmable wait states sits on the APB side; a
//               transaction-level reference model predicts each response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

  localparam int T = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- APB slave: memory plus programmable wait states ----------
  logic [31:0] slave_mem [256];
  int          wait_req = 0;   // ACCESS edges with PREADY low before it rises
  bit          stall = 1'b0;   // hold PREADY low indefinitely
  int          acc_cnt = 0;

  always_comb PREADY = !stall && (acc_cnt >= wait_req);
  always_comb PRDATA = (PSEL && PENABLE) ? slave_mem[PADDR] : 32'hBAD0_BAD0;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) slave_mem[PADDR] <= PWDATA;
  end

  // ---------------- Reference model -------------------------------------------
  logic [31:0] ref_mem [256];

  // Predicts one transfer: a transfer either completes after its wait states or
  // aborts once T ACCESS edges pass without ready; only completed writes land.
  function automatic void model(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                input int waits, output int lat, output logic err,
                                output logic [31:0] rd);
    if (waits < 0 || waits >= T) begin
      err = 1'b1; rd = 32'h0; lat = T + 1;
    end else begin
      err = 1'b0; lat = waits + 2;
      rd = wr ? 32'h0 : ref_mem[a];
      if (wr) ref_mem[a] = d;
    end
  endfunction

  // ---------------- Transaction driver / observer -----------------------------
  typedef struct {
    bit          accepted;
    bit          got;
    int          acc;
    int          lat;
    int          psel_n;
    int          pen_n;
    int          first_psel;
    int          first_pen;
    bit          fields_ok;
    bit          ready_low;
    bit          sel_at_rsp;
    logic        err;
    logic        wr;
    logic [31:0] rdata;
  } obs_t;

  // Drives one command from a negedge and records what the DUT did until the
  // response strobe; ends on the negedge where rsp_valid is seen.
  task automatic run_txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input int waits, input bit keep, output obs_t o);
    int tries = 0;
    o = '{default: 0};
    o.first_psel = -1; o.first_pen = -1;
    wait_req = (waits < 0) ? 0 : waits;
    stall = (waits < 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && tries < 20) begin
      @(negedge PCLK);
      tries++;
    end
    if (cmd_ready) begin
      o.accepted = 1'b1; o.acc = cyc + 1; o.fields_ok = 1'b1; o.ready_low = 1'b1;
      for (int i = 0; i < 64 && !o.got; i++) begin
        @(negedge PCLK);
        if (!keep) cmd_valid = 1'b0;
        if (rsp_valid) begin
          o.got = 1'b1; o.lat = cyc - o.acc; o.err = rsp_err; o.wr = rsp_write;
          o.rdata = rsp_rdata; o.sel_at_rsp = PSEL | PENABLE;
        end else begin
          if (cmd_ready) o.ready_low = 1'b0;
          if (PSEL) begin
            o.psel_n++;
            if (o.first_psel < 0) o.first_psel = cyc - o.acc;
            if (PADDR !== a || PWRITE !== wr || PWDATA !== d) o.fields_ok = 1'b0;
          end
          if (PENABLE) begin
            o.pen_n++;
            if (o.first_pen < 0) o.first_pen = cyc - o.acc;
          end
        end
      end
    end else begin
      cmd_valid = 1'b0;
    end
    stall = 1'b0;
  endtask

  // ---------------- Tests -----------------------------------------------------
  task automatic test_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 32'h1234_5678;
    repeat (3) @(negedge PCLK);
    n_cmp++; if ({cmd_ready, PSEL, PENABLE, PWRITE} !== 4'b1000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 1000", {cmd_ready, PSEL, PENABLE, PWRITE}); end
    n_cmp++; if (PADDR !== 8'h0 || PWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", PADDR, PWDATA); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_write} !== 3'b000 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp: got %b/%h want 000/0", {rsp_valid, rsp_err, rsp_write}, rsp_rdata); end
    cmd_valid = 1'b0;
    PRESET = 1'b0;
  endtask

  task automatic test_write_zero_wait();
    obs_t o; int lat; logic err; logic [31:0] rd;
    model(1'b1, 8'h10, 32'hDEAD_BEEF, 0, lat, err, rd);
    run_txn(1'b1, 8'h10, 32'hDEAD_BEEF, 0, 1'b0, o);
    n_cmp++; if (!o.got) begin n_fail++; $display("FAIL wr0_response: accepted=%0d got=%0d want 1/1", o.accepted, o.got); end
    n_cmp++; if (o.first_psel !== 0 || o.first_pen !== 1) begin n_fail++; $display("FAIL wr0_phase_timing: psel@%0d penable@%0d want 0/1", o.first_psel, o.first_pen); end
    n_cmp++; if (!o.fields_ok) begin n_fail++; $display("FAIL wr0_fields: addr/data/dir not held, got 0 want 1"); end
    n_cmp++; if (o.lat !== lat) begin n_fail++; $display("FAIL wr0_latency: got %0d want %0d", o.lat, lat); end
    n_cmp++; if ({o.err, o.wr} !== {err, 1'b1} || o.rdata !== rd) begin n_fail++; $display("FAIL wr0_rsp: got err=%b wr=%b rd=%h want %b/1/%h", o.err, o.wr, o.rdata, err, rd); end
    n_cmp++; if (o.sel_at_rsp !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr0_idle_after: sel=%b ready=%b want 0/1", o.sel_at_rsp, cmd_ready); end
  endtask

  task automatic test_readback();
    obs_t o; int lat; logic err; logic [31:0] rd;
    model(1'b0, 8'h10, 32'h0, 0, lat, err, rd);
    run_txn(1'b0, 8'h10, 32'h0, 0, 1'b0, o);
    n_cmp++; if (!o.got || o.rdata !== rd) begin n_fail++; $display("FAIL readback_data: got %h want %h", o.rdata, rd); end
    n_cmp++; if (o.wr !== 1'b0 || o.err !== err || !o.fields_ok) begin n_fail++; $display("FAIL readback_dir: wr=%b err=%b fields=%0d want 0/%b/1", o.wr, o.err, o.fields_ok, err); end
  endtask

  task automatic test_wait_states();
    obs_t o; int lat; logic err; logic [31:0] rd;
    // T-1 wait states: ready arrives on the edge that would otherwise time out.
    model(1'b0, 8'h10, 32'h0, 3, lat, err, rd);
    run_txn(1'b0, 8'h10, 32'h0, 3, 1'b0, o);
    n_cmp++; if (o.pen_n !== 4 || !o.fields_ok) begin n_fail++; $display("FAIL wait_penable: cycles=%0d fields=%0d want 4/1", o.pen_n, o.fields_ok); end
    n_cmp++; if (o.lat !== lat) begin n_fail++; $display("FAIL wait_latency: got %0d want %0d", o.lat, lat); end
    n_cmp++; if (!o.ready_low) begin n_fail++; $display("FAIL wait_cmd_ready: got high during transfer want low"); end
    n_cmp++; if (o.err !== err || o.rdata !== rd) begin n_fail++; $display("FAIL wait_rsp: err=%b rd=%h want %b/%h", o.err, o.rdata, err, rd); end
  endtask

  task automatic test_timeout();
    obs_t o; int lat; logic err; logic [31:0] rd;
    model(1'b1, 8'h20, 32'hCAFE_F00D, -1, lat, err, rd);
    run_txn(1'b1, 8'h20, 32'hCAFE_F00D, -1, 1'b0, o);
    n_cmp++; if (o.err !== err || o.rdata !== rd) begin n_fail++; $display("FAIL timeout_rsp: err=%b rd=%h want %b/%h", o.err, o.rdata, err, rd); end
    n_cmp++; if (o.lat !== lat || o.pen_n !== T) begin n_fail++; $display("FAIL timeout_timing: lat=%0d access=%0d want %0d/%0d", o.lat, o.pen_n, lat, T); end
    n_cmp++; if (o.sel_at_rsp !== 1'b0) begin n_fail++; $display("FAIL timeout_sel_drop: got %b want 0", o.sel_at_rsp); end
    // The aborted write must not have reached the slave.
    model(1'b0, 8'h20, 32'h0, 0, lat, err, rd);
    run_txn(1'b0, 8'h20, 32'h0, 0, 1'b0, o);
    n_cmp++; if (!o.got || o.lat !== lat || o.err !== err || o.rdata !== rd) begin n_fail++; $display("FAIL timeout_next_cmd: got=%0d lat=%0d err=%b rd=%h want 1/%0d/%b/%h", o.got, o.lat, o.err, o.rdata, lat, err, rd); end
  endtask

  task automatic test_reset_mid_access();
    obs_t o; int lat; logic err; logic [31:0] rd; int seen = 0;
    model(1'b0, 8'h10, 32'h0, 0, lat, err, rd);
    run_txn(1'b0, 8'h10, 32'h0, 0, 1'b0, o);   // leaves nonzero rsp_rdata/PADDR behind
    stall = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'hA5A5_5A5A;
    @(negedge PCLK);   // SETUP
    cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);   // ACCESS with wait states
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    stall = 1'b0;
    n_cmp++; if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_write} !== 7'b1000000) begin n_fail++; $display("FAIL midreset_ctrl: got %b want 1000000", {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_write}); end
    n_cmp++; if (PADDR !== 8'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_data: got %h/%h/%h want 0/0/0", PADDR, PWDATA, rsp_rdata); end
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (rsp_valid) seen++;
    end
    n_cmp++; if (seen !== 0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_no_rsp: pulses=%0d ready=%b want 0/1", seen, cmd_ready); end
  endtask

  task automatic test_back_to_back();
    obs_t o; int lat; logic err; logic [31:0] rd; int prev_acc = 0;
    for (int k = 0; k < 8; k++) begin
      logic        wr = ((k % 2) == 0);
      logic [7:0]  a  = 8'h40 + 8'(k / 2);
      logic [31:0] d  = $urandom;
      model(wr, a, d, 0, lat, err, rd);
      run_txn(wr, a, d, 0, 1'b1, o);
      n_cmp++; if (!o.got || o.err !== err || o.wr !== wr || o.rdata !== rd) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got=%0d err=%b wr=%b rd=%h want 1/%b/%b/%h", k, o.got, o.err, o.wr, o.rdata, err, wr, rd); end
      if (k > 0) begin
        n_cmp++; if (o.acc - prev_acc !== 3) begin n_fail++; $display("FAIL b2b_interval[%0d]: got %0d want 3", k, o.acc - prev_acc); end
      end
      prev_acc = o.acc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_random();
    obs_t o; int lat; logic err; logic [31:0] rd;
    for (int k = 0; k < 24; k++) begin
      logic        wr = 1'($urandom_range(0, 1));
      logic [7:0]  a  = 8'h80 + 8'($urandom_range(0, 3));
      logic [31:0] d  = $urandom;
      int          w  = $urandom_range(0, 5);
      model(wr, a, d, w, lat, err, rd);
      run_txn(wr, a, d, w, 1'($urandom_range(0, 1)), o);
      cmd_valid = 1'b0;
      n_cmp++; if (!o.got || o.lat !== lat || o.err !== err || o.rdata !== rd || o.pen_n !== lat - 1) begin n_fail++; $display("FAIL rand[%0d] wr=%b w=%0d: got=%0d lat=%0d err=%b rd=%h acc=%0d want 1/%0d/%b/%h/%0d", k, wr, w, o.got, o.lat, o.err, o.rdata, o.pen_n, lat, err, rd, lat - 1); end
      if (!err) begin
        n_cmp++; if (o.wr !== wr || !o.fields_ok) begin n_fail++; $display("FAIL rand_dir[%0d]: wr=%b fields=%0d want %b/1", k, o.wr, o.fields_ok, wr); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    test_reset();
    test_write_zero_wait();
    test_readback();
    test_wait_states();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
